// File: rtl/genius_pkg.sv
// Shared types and constants for the genius sequence generator.
// sym_t       : one colour symbol (0..2 are legal, 3 is rejected)
// gen_state_t : sequence generation FSM states
package genius_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    GEN  = 2'd2
  } gen_state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          NUM_SYMBOLS  = 3;

endpackage

// File: rtl/genius_sequence_gen_if.sv
// Control and read-port bundle between the game core (master) and the
// sequence generator (slave).
// master drives : new_game, sw, extend, rd_en, rd_idx
// slave drives  : rd_data, rd_valid, rd_oob, length, full, busy,
//                 ext_done, err_full
interface genius_sequence_gen_if #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic             new_game;
  logic [7:0]       sw;
  logic             extend;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [SYM_W-1:0] rd_data;
  logic             rd_valid;
  logic             rd_oob;
  logic [LEN_W-1:0] length;
  logic             full;
  logic             busy;
  logic             ext_done;
  logic             err_full;

  modport master (
    output new_game, sw, extend, rd_en, rd_idx,
    input  rd_data, rd_valid, rd_oob, length, full, busy, ext_done, err_full
  );

  modport slave (
    input  new_game, sw, extend, rd_en, rd_idx,
    output rd_data, rd_valid, rd_oob, length, full, busy, ext_done, err_full
  );

endinterface

// File: rtl/genius_lfsr.sv
// One-step Galois LFSR next-state function (shift right, XOR the mask
// when the bit shifted out is 1). Purely combinational.
// cur : current LFSR state
// nxt : state after one step
module genius_lfsr
  import genius_pkg::*;
#(
  parameter int             W    = 16,
  parameter logic [W-1:0]   MASK = W'(LFSR_MASK)
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? MASK : '0);

endmodule

// File: rtl/genius_sequence_gen.sv
// Pattern source for the genius game core: stores a pseudo-random colour
// sequence, appends one symbol per extend request and serves indexed reads.
// clock : system clock
// reset : asynchronous active-low reset
// bus   : control / read port bundle (slave side)
//
// state | meaning
// IDLE  | waiting for new_game or extend
// SEED  | reload gen LFSR from free LFSR ^ switches, clear length
// GEN   | stepping gen LFSR until a legal symbol (or forced 0) is written
module genius_sequence_gen
  import genius_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                SYM_W     = 2,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int                MAX_TRIES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  genius_sequence_gen_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [SYM_W-1:0] SYM_BAD  = SYM_W'(NUM_SYMBOLS);

  gen_state_t        state, state_nxt;
  logic [LFSR_W-1:0] free_lfsr, free_nxt;
  logic [LFSR_W-1:0] gen_lfsr, gen_nxt, seed_mix;
  logic [TRY_W-1:0]  tries_left;
  logic [LEN_W-1:0]  length_q;
  logic [SYM_W-1:0]  mem [DEPTH];
  logic [SYM_W-1:0]  cand, wr_sym, rd_data_q;
  logic              load_seed, gen_step, wr_en, tries_load, tries_dec;
  logic              ext_done_nxt, err_full_nxt;
  logic              ext_done_q, err_full_q, rd_valid_q, rd_oob_q, full;

  genius_lfsr #(.W(LFSR_W)) u_free_lfsr (.cur(free_lfsr), .nxt(free_nxt));
  genius_lfsr #(.W(LFSR_W)) u_gen_lfsr  (.cur(gen_lfsr),  .nxt(gen_nxt));

  assign cand     = gen_nxt[SYM_W-1:0];
  assign seed_mix = free_lfsr ^ LFSR_W'({bus.sw, bus.sw});
  assign full     = (length_q == LEN_FULL);

  // new_game overrides every state, so an in-flight GEN is dropped
  // without a write and a coincident extend is lost.
  always_comb begin
    state_nxt    = state;
    load_seed    = 1'b0;
    gen_step     = 1'b0;
    wr_en        = 1'b0;
    wr_sym       = '0;
    tries_load   = 1'b0;
    tries_dec    = 1'b0;
    ext_done_nxt = 1'b0;
    err_full_nxt = 1'b0;
    if (bus.new_game) begin
      state_nxt = genius_pkg::SEED;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.extend) begin
            if (full) begin
              err_full_nxt = 1'b1;
            end else begin
              state_nxt  = GEN;
              tries_load = 1'b1;
            end
          end
        end
        genius_pkg::SEED: begin
          load_seed = 1'b1;
          state_nxt = IDLE;
        end
        GEN: begin
          gen_step = 1'b1;
          if (cand != SYM_BAD || tries_left == '0) begin
            // the last permitted attempt turns an illegal 3 into 0
            wr_en        = 1'b1;
            wr_sym       = (cand == SYM_BAD) ? '0 : cand;
            ext_done_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            tries_dec = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      free_lfsr  <= SEED;
      gen_lfsr   <= SEED;
      tries_left <= '0;
      length_q   <= '0;
      ext_done_q <= 1'b0;
      err_full_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      free_lfsr  <= free_nxt;
      ext_done_q <= ext_done_nxt;
      err_full_q <= err_full_nxt;
      if (load_seed) begin
        gen_lfsr <= (seed_mix == '0) ? SEED : seed_mix;
      end else if (gen_step) begin
        gen_lfsr <= gen_nxt;
      end
      if (tries_load) begin
        tries_left <= TRY_LAST;
      end else if (tries_dec) begin
        tries_left <= tries_left - 1'b1;
      end
      if (load_seed) begin
        length_q <= '0;
      end else if (wr_en && !full) begin
        length_q <= length_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !full) begin
      mem[length_q[IDX_W-1:0]] <= wr_sym;
    end
  end

  // Reads compare against the length before any same-cycle append.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en && (LEN_W'(bus.rd_idx) < length_q)) begin
        rd_oob_q  <= 1'b0;
        rd_data_q <= mem[bus.rd_idx];
      end else begin
        rd_oob_q  <= bus.rd_en;
        rd_data_q <= '0;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_oob   = rd_oob_q;
  assign bus.length   = length_q;
  assign bus.full     = full;
  assign bus.busy     = (state == GEN);
  assign bus.ext_done = ext_done_q;
  assign bus.err_full = err_full_q;

endmodule

// File: doc/genius_sequence_gen.md
Name: genius_sequence_gen

Overview:
- Upstream pattern source for the genius game core.
- Produces and stores the pseudo-random colour sequence that the core plays back and checks against button presses.
- Each new game reseeds from a free-running LFSR mixed with the board switches.
- On each level-up, appends one symbol in the range 0..2 (one per button) and serves random-access reads of the stored sequence.

Parameters:
- DEPTH, 16, maximum sequence length (matches the 4-bit level counter).
- SYM_W, 2, symbol width; legal symbols are 0, 1, 2.
- LFSR_W, 16, LFSR width.
- SEED, 16'hACE1, reset and fallback seed (must be non-zero).
- MAX_TRIES, 8, generation attempts before a forced fallback.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- new_game  in  1  single-cycle pulse: clear sequence and reseed
- sw  in  8  switch value mixed into the seed
- extend  in  1  single-cycle pulse: append one symbol
- rd_en  in  1  read request
- rd_idx  in  4  read index
- rd_data  out  SYM_W  symbol read
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- rd_oob  out  1  with rd_valid: rd_idx >= length
- length  out  5  stored symbols, 0..DEPTH
- full  out  1  length == DEPTH
- busy  out  1  generation in progress
- ext_done  out  1  one-cycle pulse: symbol appended
- err_full  out  1  one-cycle pulse: extend ignored because full

Behaviour:
- Reset values: all outputs 0; free LFSR and gen LFSR = SEED; state IDLE; memory contents are don't-care.
- Free LFSR:
  - 16-bit Galois LFSR, mask 16'hB400, shift right; if the shifted-out bit is 1, XOR the mask.
  - Steps every cycle from reset release and is never stalled.
- Sequence generation FSM, states IDLE, SEED, GEN:
  - IDLE, new_game=1 -> SEED.
  - SEED, 1 cycle:
    - gen LFSR <= free LFSR ^ {sw, sw}; if the result is 0, load SEED instead.
    - length <= 0.
    - -> IDLE.
  - IDLE, extend=1, full=0 -> GEN; busy=1 from the next cycle.
  - IDLE, extend=1, full=1 -> err_full pulses for 1 cycle; state and length unchanged.
  - GEN, each cycle:
    - Step the gen LFSR and take cand = low 2 bits of the stepped value.
    - If cand != 3: write mem[length] <= cand, length++, pulse ext_done, -> IDLE.
    - If cand == 3 and the attempt count is below MAX_TRIES: stay in GEN.
    - On the MAX_TRIES-th attempt, cand 3 is written as 0.
  - Latency: ext_done arrives 2..MAX_TRIES+1 cycles after extend; busy drops in the same cycle ext_done asserts.
- extend while busy is ignored, with no error pulse.
- new_game has priority over everything, in any state:
  - GEN is aborted with no write and no ext_done; -> SEED.
  - A simultaneous extend is dropped.
- Read port:
  - rd_en sampled at edge N -> rd_data and rd_valid at edge N+1.
  - rd_valid is a one-cycle pulse per rd_en.
  - If rd_idx >= length at edge N: rd_data=0, rd_oob=1.
- Reads are legal during busy. A read of the index being written in the same cycle returns the pre-write view (oob).
- length saturates at DEPTH; it never wraps.
- Asynchronous reset mid-GEN returns everything to reset values immediately.

Decomposition:
- Shared package genius_pkg holds:
  - sym_t (logic [1:0])
  - gen_state_t enum {IDLE, SEED, GEN}
  - LFSR_MASK = 16'hB400
  - DEFAULT_SEED = 16'hACE1
  - NUM_SYMBOLS = 3
- Sub-module genius_lfsr: combinational one-step Galois next-state function, instantiated twice (free LFSR and gen LFSR).
- The memory is an inferred register array inside genius_sequence_gen.

Test Plan:
- Reset held low 3 cycles, then released -> length=0, full=0, busy=0, all pulses 0; rd_en with rd_idx=0 -> rd_valid=1, rd_oob=1, rd_data=0 one cycle later.
- new_game then 16 extend pulses, each issued after the previous ext_done -> 16 ext_done pulses; length=16, full=1; reading indices 0..15 gives rd_oob=0 and every rd_data in {0,1,2}.
- With full=1, extend -> err_full=1 for exactly 1 cycle; length stays 16, no ext_done, busy stays 0.
- Two runs, each with reset then new_game at cycle 20 with sw=8'h5A, followed by 10 extends -> identical 10-symbol sequences; the same with sw=8'hA5 gives a different sequence.
- extend, then new_game on the cycle after busy rises -> no ext_done; length=0 two cycles later; a subsequent extend gives length=1.
- Force the gen LFSR into a state whose next 8 candidates are all 3 (white-box preload) -> ext_done on attempt 8; the stored symbol is 0.
